// File: rtl/approx_accum_pkg.sv
// Shared types and default widths for the approximate-product accumulator.
// Also provides the saturation ceiling helper for the adder.
package approx_accum_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int PROD_W_DEF = 16;
  localparam int ACC_W_DEF  = 24;
  localparam int CNT_W_DEF  = 8;

  // Largest unsigned value representable in w bits (w <= 63).
  function automatic logic [63:0] sat_max(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/sat_add_u.sv
// Combinational unsigned saturating adder: acc + zero-extended product,
// clamped to all ones when the true sum does not fit in ACC_W bits.
module sat_add_u
  import approx_accum_pkg::*;
#(
  parameter int ACC_W  = ACC_W_DEF,
  parameter int PROD_W = PROD_W_DEF
) (
  input  logic [ACC_W-1:0]  i_a,
  input  logic [PROD_W-1:0] i_b,
  output logic [ACC_W-1:0]  o_sum,
  output logic              o_sat
);

  localparam logic [ACC_W-1:0] SAT_MAX = ACC_W'(sat_max(ACC_W));

  logic [ACC_W:0] w_full;

  // One guard bit is enough: the carry out means the sum overflowed.
  assign w_full = {1'b0, i_a} + {{(ACC_W + 1 - PROD_W){1'b0}}, i_b};
  assign o_sat  = w_full[ACC_W];
  assign o_sum  = o_sat ? SAT_MAX : w_full[ACC_W-1:0];

endmodule

// File: rtl/approx_prod_accum.sv
// Registered back-end for the approximate multiplier: accumulates a programmed
// number of products into a saturating sum and hands it off over valid/ready.
module approx_prod_accum
  import approx_accum_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [CNT_W-1:0]  i_len,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [PROD_W-1:0] i_in_prod,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [ACC_W-1:0]  o_out_acc,
  output logic [CNT_W-1:0]  o_out_cnt,
  output logic              o_out_ovf,
  output logic              o_busy
);

  state_t             r_state, w_next;
  logic [ACC_W-1:0]   r_acc, w_sum;
  logic [CNT_W-1:0]   r_cnt, r_rem;
  logic               r_ovf, w_sat, w_beat;

  assign w_beat = i_in_valid && (r_state == ACCUM);

  sat_add_u #(.ACC_W(ACC_W), .PROD_W(PROD_W)) u_add (
    .i_a   (r_acc),
    .i_b   (i_in_prod),
    .o_sum (w_sum),
    .o_sat (w_sat)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (i_start) w_next = (i_len == '0) ? DONE : ACCUM;
      ACCUM:   if (w_beat && r_rem == CNT_W'(1)) w_next = DONE;
      DONE:    if (i_out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    o_in_ready  = (r_state == ACCUM);
    o_out_valid = (r_state == DONE);
    o_busy      = (r_state != IDLE);
  end

  // Result registers only move on start or on an accepted beat, so they hold in DONE.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_rem <= '0;
      r_ovf <= 1'b0;
    end else if (r_state == IDLE && i_start) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_rem <= i_len;
      r_ovf <= 1'b0;
    end else if (w_beat) begin
      r_acc <= w_sum;
      r_cnt <= r_cnt + CNT_W'(1);
      r_rem <= r_rem - CNT_W'(1);
      r_ovf <= r_ovf | w_sat;
    end
  end

  assign o_out_acc = r_acc;
  assign o_out_cnt = r_cnt;
  assign o_out_ovf = r_ovf;

endmodule

// File: tb/tb_approx_prod_accum.sv
// Directed bench: two instances (ACC_W=24 and ACC_W=20) share one stimulus
// stream and are compared every cycle against a run-level sum/count model.
module tb_approx_prod_accum;

  localparam longint MAX0 = 64'd16777215;  // 2^24-1
  localparam longint MAX1 = 64'd1048575;   // 2^20-1

  logic        clk = 1'b0;
  logic        rst, start, in_valid, out_ready;
  logic [7:0]  len;
  logic [15:0] prod;

  logic        rdy0, val0, ovf0, busy0;
  logic        rdy1, val1, ovf1, busy1;
  logic [23:0] acc0;
  logic [19:0] acc1;
  logic [7:0]  cnt0, cnt1;

  int checks = 0;
  int failures = 0;

  approx_prod_accum #(.PROD_W(16), .ACC_W(24), .CNT_W(8)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_len(len),
    .i_in_valid(in_valid), .o_in_ready(rdy0), .i_in_prod(prod),
    .o_out_valid(val0), .i_out_ready(out_ready), .o_out_acc(acc0),
    .o_out_cnt(cnt0), .o_out_ovf(ovf0), .o_busy(busy0)
  );

  approx_prod_accum #(.PROD_W(16), .ACC_W(20), .CNT_W(8)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_len(len),
    .i_in_valid(in_valid), .o_in_ready(rdy1), .i_in_prod(prod),
    .o_out_valid(val1), .i_out_ready(out_ready), .o_out_acc(acc1),
    .o_out_cnt(cnt1), .o_out_ovf(ovf1), .o_busy(busy1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase 0=idle 1=collecting 2=result pending; true (unclamped) sum of products.
  int     ph = 0;
  longint msum = 0;
  int     mcnt = 0;
  int     target = 0;
  int     xf0 = 0, xf1 = 0;
  bit     chk_en = 0;

  always @(posedge clk) begin
    if (val0 && out_ready) xf0++;
    if (val1 && out_ready) xf1++;
    if (rst) begin
      ph = 0; msum = 0; mcnt = 0;
    end else begin
      case (ph)
        0: if (start) begin
             msum = 0; mcnt = 0; target = len;
             ph = (len == 0) ? 2 : 1;
           end
        1: if (in_valid) begin
             msum += prod; mcnt++;
             if (mcnt == target) ph = 2;
           end
        default: if (out_ready) ph = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy0", busy0, ph != 0);
      chk("in_ready0", rdy0, ph == 1);
      chk("out_valid0", val0, ph == 2);
      chk("out_acc0", acc0, (msum > MAX0) ? MAX0 : msum);
      chk("out_cnt0", cnt0, mcnt);
      chk("out_ovf0", ovf0, msum > MAX0);
      chk("busy1", busy1, ph != 0);
      chk("in_ready1", rdy1, ph == 1);
      chk("out_valid1", val1, ph == 2);
      chk("out_acc1", acc1, (msum > MAX1) ? MAX1 : msum);
      chk("out_cnt1", cnt1, mcnt);
      chk("out_ovf1", ovf1, msum > MAX1);
    end
  end

  task automatic do_start(input logic [7:0] l);
    start = 1'b1; len = l;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic beat(input logic [15:0] p);
    in_valid = 1'b1; prod = p;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic accept();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int x0;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    len = '0; prod = '0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    chk_en = 1;
    chk("reset_acc", acc0, 0);
    chk("reset_valid", val0, 0);
    chk("reset_busy", busy0, 0);

    // Basic run, back-to-back beats, consumer always ready.
    out_ready = 1'b1;
    do_start(8'd4);
    beat(16'd100); beat(16'd200); beat(16'd300); beat(16'd400);
    chk("basic_valid_lat1", val0, 1);
    chk("basic_acc", acc0, 1000);
    chk("basic_cnt", cnt0, 4);
    chk("basic_ovf", ovf0, 0);
    chk("model_basic_sum", msum, 1000);
    @(negedge clk);
    chk("basic_back_idle", busy0, 0);
    out_ready = 1'b0;

    // Gaps between beats, then 5 cycles of backpressure.
    x0 = xf0;
    do_start(8'd3);
    beat(16'hFFFF);
    @(negedge clk);
    beat(16'd1);
    @(negedge clk); @(negedge clk);
    beat(16'd2);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid_held", val0, 1);
      chk("bp_acc_held", acc0, 65538);
      chk("bp_in_ready_low", rdy0, 0);
      @(negedge clk);
    end
    accept();
    chk("bp_one_transfer", xf0 - x0, 1);
    chk("bp_valid_drop", val0, 0);

    // Saturation: 17 * 0xFFFF overflows 20 bits but not 24.
    do_start(8'd17);
    for (int i = 0; i < 17; i++) beat(16'hFFFF);
    chk("sat_acc20", acc1, 20'hFFFFF);
    chk("sat_ovf20", ovf1, 1);
    chk("sat_cnt20", cnt1, 17);
    chk("sat_acc24", acc0, 1114095);
    chk("sat_ovf24", ovf0, 0);
    accept();

    // Empty vector: straight to result, sticky overflow cleared by start.
    do_start(8'd0);
    chk("empty_valid", val0, 1);
    chk("empty_acc", acc0, 0);
    chk("empty_cnt", cnt0, 0);
    chk("empty_ovf20_cleared", ovf1, 0);
    accept();

    // Reset mid-run discards the partial sum.
    do_start(8'd5);
    beat(16'd10); beat(16'd20);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_acc", acc0, 0);
    chk("rst_cnt", cnt0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_in_ready", rdy0, 0);
    do_start(8'd2);
    beat(16'd7); beat(16'd8);
    chk("post_rst_acc", acc0, 15);
    chk("post_rst_cnt", cnt0, 2);
    accept();

    // Start pulsed mid-run must be ignored.
    do_start(8'd2);
    beat(16'd3);
    start = 1'b1; len = 8'd9;
    @(negedge clk);
    start = 1'b0;
    beat(16'd4);
    chk("ign_valid", val0, 1);
    chk("ign_cnt", cnt0, 2);
    chk("ign_acc", acc0, 7);
    accept();
    @(negedge clk);
    chk("ign_no_new_run", busy0, 0);

    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/approx_prod_accum.md
Name: approx_prod_accum

Overview:
Downstream consumer stage for the 8x8 approximate multiplier. It accepts a stream of 16-bit approximate products over a valid/ready handshake and accumulates a programmed number of them into a saturating sum, which is a dot-product style reduction. The result is presented on an output valid/ready handshake. It provides the registered, sequential back-end that the combinational multiplier lacks, and it is used for accuracy and error characterisation of approximate dot products.

Parameters:
PROD_W, 16, width of incoming product (matches multiplier R width)
ACC_W, 24, accumulator and result width; must be >= PROD_W
CNT_W, 8, width of length/count fields; max vector length 2^CNT_W-1

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
start  in  1  begin a new accumulation; honoured only in IDLE
len  in  CNT_W  number of products to accumulate; sampled with start
in_valid  in  1  in_prod is valid
in_ready  out  1  block accepts a product this cycle
in_prod  in  PROD_W  unsigned product from the multiplier
out_valid  out  1  result available
out_ready  in  1  consumer accepts the result
out_acc  out  ACC_W  accumulated sum (saturated)
out_cnt  out  CNT_W  number of products actually accumulated
out_ovf  out  1  sticky: saturation occurred during this run
busy  out  1  high in ACCUM or DONE

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; acc=0; cnt=0; remaining=0; ovf=0. All outputs are 0: in_ready, out_valid, out_acc, out_cnt, out_ovf, busy. Reset overrides every other input, including mid-run; any partial sum is discarded.
- States are IDLE, ACCUM and DONE.
- IDLE: in_ready=0, out_valid=0.
  - start=1 and len!=0: acc<=0, cnt<=0, ovf<=0, remaining<=len; next state ACCUM.
  - start=1 and len==0: acc<=0, cnt<=0, ovf<=0; next state DONE (empty result).
- ACCUM: in_ready=1. A beat is in_valid & in_ready.
  - On a beat: acc<=sat(acc+in_prod); cnt<=cnt+1; remaining<=remaining-1.
  - A beat with remaining==1 moves to DONE. out_valid rises the cycle after the last accepted beat (latency 1 cycle).
  - Cycles with in_valid=0 are idle gaps; there is no timeout.
- DONE: out_valid=1 and in_ready=0.
  - out_acc, out_cnt and out_ovf are registered and held stable until out_valid & out_ready.
  - On acceptance: next state IDLE, and out_valid=0 in the following cycle.
- start is ignored in ACCUM and DONE. A new start is honoured at the earliest in the first IDLE cycle after acceptance (one bubble cycle).
- Arithmetic:
  - in_prod is zero-extended to ACC_W+1 bits before the add.
  - If the sum exceeds 2^ACC_W-1, acc<=all ones and ovf<=1.
  - ovf is sticky for the run. Once saturated, acc stays at all ones.
- out_acc, out_cnt and out_ovf drive directly from the acc, cnt and ovf registers (no combinational path from inputs). in_ready and out_valid decode directly from the state register.
- busy = (state != IDLE).
- Products are never dropped or double-counted: out_cnt equals len at every DONE.

Decomposition:
- Package approx_accum_pkg holds:
  - the state enum (IDLE, ACCUM, DONE);
  - default widths PROD_W=16, ACC_W=24, CNT_W=8;
  - a constant function for the saturation maximum.
- One sub-module, sat_add_u: a combinational unsigned saturating adder, parameterised on ACC_W and PROD_W, with outputs sum and sat. The FSM, counters and handshake stay in approx_prod_accum.

Test Plan:
- Basic run: start with len=4; products 100, 200, 300, 400 on back-to-back beats; out_ready=1 -> out_valid asserted 1 cycle after the 4th beat with out_acc=1000, out_cnt=4, out_ovf=0; state returns to IDLE.
- Gaps and backpressure: len=3; products 0xFFFF, 1, 2 with idle cycles between beats; out_ready held 0 for 5 cycles -> out_acc=65538 held stable and out_valid held for all 5 cycles; in_ready=0 throughout DONE; exactly one output transfer occurs.
- Saturation (ACC_W=20 instance): len=17, all products 0xFFFF -> out_acc=0xFFFFF, out_ovf=1, out_cnt=17.
- Empty vector: start with len=0 -> out_valid one cycle later with out_acc=0, out_cnt=0, out_ovf=0; no product is accepted (in_ready never asserted).
- Reset mid-run: len=5; accept 2 beats; assert rst for 1 cycle -> all outputs 0 the next cycle. A following run with len=2 and products 7, 8 gives out_acc=15, with no residue from the aborted run.
- Ignored start: pulse start with len=9 during ACCUM of a len=2 run -> that run completes with out_cnt=2; the second start has no effect.
